// File: rtl/showcase_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : showcase_delay_line
//  Purpose  : Programmable delay line backed by a small circular buffer.
//             Every cycle the input sample and its qualifier are written to
//             the buffer. The output is read back dly+2 cycles later.
//             A peak tracker and a saturating count of valid outputs are kept.
//  Ports    : clk       - clock, rising edge
//             rst_n     - asynchronous active-low reset
//             din       - input sample            din_vld  - din qualifier
//             cfg_dly   - new delay code          cfg_we   - load cfg_dly
//             clr       - synchronous clear of peak / cnt / cnt_sat
//             dout      - delayed sample (reg)    dout_vld - dout qualifier (reg)
//             flushing  - output masked after a configuration write
//             peak      - largest valid dout since reset / clr
//             cnt       - valid dout count, saturating
//             cnt_sat   - sticky, cnt reached all-ones
//  Revision : 1.0 - initial release
// ============================================================================
module showcase_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = 16,
    parameter bit SIGNED     = 1'b0,
    parameter int DLY_INIT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_vld,
    input  logic [ADDR_WIDTH-1:0] cfg_dly,
    input  logic                  cfg_we,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  flushing,
    output logic [DATA_WIDTH-1:0] peak,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  cnt_sat
);

    localparam int c_DEPTH   = 2 ** ADDR_WIDTH;
    // DEPTH+1 always fits in ADDR_WIDTH+1 bits
    localparam int c_FLUSH_W = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [c_FLUSH_W-1:0]  c_FLUSH_ONE  = c_FLUSH_W'(1);
    localparam logic [c_FLUSH_W-1:0]  c_FLUSH_LOAD = c_FLUSH_W'(c_DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_PEAK_MIN   =
        SIGNED ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}};

    // Buffer storage: data without reset, qualifiers with reset so that
    // stale data can never surface as a valid output.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]    r_slot_vld;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_dly;
    logic [c_FLUSH_W-1:0]  r_flush_cnt;
    logic                  r_flushing;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_vld;
    logic [DATA_WIDTH-1:0] r_peak;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_cnt_sat;

    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [c_FLUSH_W-1:0]  w_flush_nxt;
    logic                  w_gt;

    // Read happens before the same-cycle write, so dly = DEPTH-1 sees the
    // slot that is about to be overwritten.
    assign w_rd_addr = r_wr_ptr - r_dly - c_ADDR_ONE;

    // Flush countdown; any configuration write (re)starts it.
    always_comb begin
        w_flush_nxt = '0;
        if (cfg_we) begin
            w_flush_nxt = c_FLUSH_LOAD;
        end else if (r_flush_cnt != '0) begin
            w_flush_nxt = r_flush_cnt - c_FLUSH_ONE;
        end
    end

    generate
        if (SIGNED) begin : g_signed_cmp
            assign w_gt = $signed(r_dout) > $signed(r_peak);
        end else begin : g_unsigned_cmp
            assign w_gt = r_dout > r_peak;
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_vld  <= '0;
            r_wr_ptr    <= '0;
            r_dly       <= ADDR_WIDTH'(DLY_INIT);
            r_flush_cnt <= '0;
            r_flushing  <= 1'b0;
        end else begin
            r_slot_vld[r_wr_ptr] <= din_vld;
            r_wr_ptr             <= r_wr_ptr + c_ADDR_ONE;
            r_flush_cnt          <= w_flush_nxt;
            r_flushing           <= (w_flush_nxt != '0);
            if (cfg_we) begin
                r_dly <= cfg_dly;
            end
        end
    end

    // Output stage: masking follows the flag that becomes visible together
    // with this output, so dout_vld is never high while flushing is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else if (w_flush_nxt != '0) begin
            r_dout_vld <= 1'b0;
        end else begin
            r_dout     <= r_mem[w_rd_addr];
            r_dout_vld <= r_slot_vld[w_rd_addr];
        end
    end

    // Statistics over presented outputs; clr wins over a same-cycle output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak    <= c_PEAK_MIN;
            r_cnt     <= '0;
            r_cnt_sat <= 1'b0;
        end else if (clr) begin
            r_peak    <= c_PEAK_MIN;
            r_cnt     <= '0;
            r_cnt_sat <= 1'b0;
        end else if (r_dout_vld) begin
            if (w_gt) begin
                r_peak <= r_dout;
            end
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_ONE;
                if (r_cnt == (c_CNT_MAX - c_CNT_ONE)) begin
                    r_cnt_sat <= 1'b1;
                end
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign flushing = r_flushing;
    assign peak     = r_peak;
    assign cnt      = r_cnt;
    assign cnt_sat  = r_cnt_sat;

endmodule
`default_nettype wire

// File: doc/showcase_delay_line.md
# showcase_delay_line

Parametrised, programmable delay line with valid qualification and output statistics. It generalises the fixed two-stage `i` register chain and small ROM/RAM style of the showcase family into a RAM-backed circular buffer. Depth, data width, signedness and delay are configurable, and it adds a peak tracker and a saturating sample counter. It sits between a sample source and downstream logic that needs a run-time-adjustable latency.

## Interface
- DATA_WIDTH, 8, width of din/dout/peak
- ADDR_WIDTH, 2, buffer depth DEPTH = 2**ADDR_WIDTH
- CNT_WIDTH, 16, width of sample counter
- SIGNED, 0, 1 = peak comparison treats data as two's complement
- DLY_INIT, 0, reset value of the delay register (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- din  in  DATA_WIDTH  input sample
- din_vld  in  1  din qualifier
- cfg_dly  in  ADDR_WIDTH  new delay code
- cfg_we  in  1  load cfg_dly into delay register
- clr  in  1  synchronous clear of peak/cnt/cnt_sat
- dout  out  DATA_WIDTH  delayed sample (registered)
- dout_vld  out  1  dout qualifier (registered)
- flushing  out  1  high while output is masked after config change
- peak  out  DATA_WIDTH  largest dout seen with dout_vld since reset/clr
- cnt  out  CNT_WIDTH  number of dout_vld cycles since reset/clr, saturating
- cnt_sat  out  1  sticky: cnt reached all-ones

## Operation
- Every cycle, {din_vld, din} is written to buffer slot wr_ptr. wr_ptr increments modulo DEPTH unconditionally, so the delay is counted in cycles, not samples.
- Data is held in RAM without reset. Per-slot valid bits are DEPTH flops cleared by rst_n. Stale RAM contents can therefore never produce dout_vld=1.
- Read address = wr_ptr - (dly + 1) mod DEPTH. It is read before the same-cycle write, so the dly = DEPTH-1 case reads the slot about to be overwritten.
- dout/dout_vld register the read slot. If flushing=1 then dout_vld=0, and dout keeps its last value.
- dly register: reset to DLY_INIT; loads cfg_dly on cfg_we=1.
- On any cfg_we=1, including the same value, a flush counter loads DEPTH+1 and flushing=1. The counter decrements each cycle. flushing drops when it reaches 0. A cfg_we during a flush restarts the count.
- Peak: when dout_vld=1 and dout > peak, peak <= dout. The comparison is signed if SIGNED=1, otherwise unsigned. Equality does not update.
- cnt increments on each dout_vld=1 cycle and stops at 2**CNT_WIDTH-1. cnt_sat is set in the cycle cnt becomes all-ones and stays set.
- clr=1 sets peak to its minimum, cnt=0 and cnt_sat=0. clr has priority: a dout_vld in the clr cycle is neither counted nor peak-tracked.
- Width rules: all pointer arithmetic is ADDR_WIDTH bits, wrapping. cnt never wraps.

## Timing
- Latency L = dly + 2 cycles from din_vld/din at cycle t to dout_vld/dout at cycle t+L. Range is 2..DEPTH+1.
- peak and cnt reflect a dout_vld one cycle after it is presented. cnt_sat rises in the same cycle cnt first reads all-ones.
- New dly is effective for reads from the cycle after cfg_we. Output is masked for DEPTH+1 cycles, which covers the full buffer turnover.
- Reset values (asynchronous, immediate):
  - dout=0, dout_vld=0, flushing=0, cnt=0, cnt_sat=0
  - peak=0 if SIGNED=0, else the most negative value (e.g. 0x80)
  - wr_ptr=0, all slot valid bits=0, dly=DLY_INIT
- Reset asserted mid-stream: in-flight samples are discarded. After release, dout_vld stays 0 until the first post-reset din_vld=1 sample emerges L cycles later.
- Back-to-back din_vld=1 streams at full rate; there is no backpressure.

## Test plan
- Defaults, reset, then din=1,2,3… with din_vld=1 every cycle -> dout_vld first high 2 cycles after the first sample, dout=1,2,3…, cnt increments by 1 per cycle.
- cfg_dly=3, cfg_we pulse, then a single din=0x5A with din_vld=1 -> flushing high 5 cycles, then dout=0x5A with dout_vld=1 exactly 5 cycles after input; DEPTH=4.
- dout_vld never rises before the first din_vld=1 after reset, for every dly 0..3 (RAM stale data masked).
- SIGNED=1, input sequence 0x10, 0xF0, 0x7F, 0x80 -> peak = 0x80, 0x80, then 0x10, 0x10, 0x7F, 0x7F; repeat with SIGNED=0 -> final peak = 0xF0.
- CNT_WIDTH=4: 15 valid outputs -> cnt=15, cnt_sat=1. A 16th valid output -> cnt stays 15. clr together with a valid output -> cnt=0, cnt_sat=0, peak reset.
- Asserting rst_n low mid-stream with dly=2 -> outputs zero immediately. After release, no dout_vld until new input arrives 4 cycles earlier. A second cfg_we during flush restarts flushing for DEPTH+1 cycles.
